wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback pipeline stage of the 5-stage rv32i core. It sits directly downstream of the data-memory stage and consumes the MEM/WB pipeline register plus the data-memory response.
- It waits for the load/store response, holds it across pipeline stalls, aligns and sign-extends load data, drives the register-file write port, and produces the RVFI commit signals, including a 64-bit commit order counter.

Parameters:
- ORDER_W, 64, width of RVFI commit order counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- pipe_advance  in  1  global pipeline register write enable (same signal the MEM stage uses). Never asserted while dmem_stall=1.
- in_valid  in  1  MEM/WB register holds a real instruction.
- in_rd_addr  in  5  destination register.
- in_alu_out  in  32  ALU result / effective address.
- in_pc_next  in  32  PC+4 link value.
- in_wb_sel  in  2  0=alu_out, 1=load data, 2=pc_next, 3=reserved (writes 0).
- in_regf_we  in  1  instruction writes rd.
- in_funct3  in  3  load funct3 (lb=000, lh=001, lw=010, lbu=100, lhu=101).
- in_mem_rmask  in  4  read mask issued by MEM stage.
- in_mem_wmask  in  4  write mask issued by MEM stage.
- dmem_rdata  in  32  data-memory read word (word-aligned).
- dmem_resp  in  1  data-memory response pulse.
- dmem_stall  out  1  WB waiting for a memory response; folded into the hazard unit.
- dmem_resp_err  out  1  one-cycle pulse on an unexpected dmem_resp.
- regf_we  out  1  register-file write enable.
- regf_rd_addr  out  5  register-file write address.
- regf_wdata  out  32  register-file write data (also the forwarding source).
- rvfi_valid  out  1  instruction commits this cycle.
- rvfi_order  out  ORDER_W  commit index.
- rvfi_rd_addr  out  5  rd as committed (0 if no write).
- rvfi_rd_wdata  out  32  value written (0 if no write).
- rvfi_mem_rdata  out  32  raw dmem word for loads, else 0.

Behaviour:
- Memory access: mem_acc = in_valid & (in_mem_rmask != 0 | in_mem_wmask != 0).
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE. On rst the FSM goes to IDLE, rdata_hold=0 and order counter=0, including mid-WAIT.
- IDLE (fresh instruction in WB):
  - mem_acc & !dmem_resp: dmem_stall=1 combinationally; next state WAIT.
  - mem_acc & dmem_resp: data valid this cycle. If pipe_advance, commit and stay IDLE; else capture dmem_rdata into rdata_hold and go to DONE.
  - !mem_acc: a dmem_resp here pulses dmem_resp_err and is otherwise ignored.
- WAIT:
  - dmem_stall = !dmem_resp (deasserts in the same cycle the response arrives).
  - On dmem_resp: if pipe_advance, commit and go to IDLE; else capture into rdata_hold and go to DONE.
- DONE:
  - dmem_stall=0; load data comes from rdata_hold.
  - dmem_resp pulses dmem_resp_err and does not overwrite rdata_hold.
  - On pipe_advance, commit and go to IDLE.
- Load data source: dmem_rdata in IDLE/WAIT, rdata_hold in DONE.
- Load alignment, with off=in_alu_out[1:0]:
  - lb: sign-extend byte[8*off +: 8].
  - lbu: zero-extend the same byte.
  - lh: sign-extend half[16*in_alu_out[1] +: 16].
  - lhu: zero-extend the same half.
  - lw: full word.
  - Other funct3: 0.
- regf_wdata is selected by in_wb_sel. It is driven combinationally every cycle for forwarding, regardless of commit.
- Commit:
  - commit = pipe_advance & in_valid & !dmem_stall.
  - regf_we = commit & in_regf_we & (in_rd_addr != 0). regf_rd_addr = in_rd_addr.
  - x0 writes never assert regf_we.
- RVFI:
  - rvfi_valid = commit; all RVFI outputs are combinational.
  - rvfi_order = current counter value. Counter increments by 1 at the clock edge following each commit and wraps modulo 2^ORDER_W.
  - rvfi_rd_addr and rvfi_rd_wdata are 0 unless regf_we.
  - rvfi_mem_rdata = selected load data source when in_mem_rmask != 0, else 0.
- Stores: wait for dmem_resp exactly like loads; they never write the register file.
- Bubbles: in_valid=0 never stalls and never commits, even with pipe_advance=1.
- Output reset values: dmem_stall=0, dmem_resp_err=0, regf_we=0, rvfi_valid=0, rvfi_order=0. In the cycle after rst, all other outputs follow the reset MEM/WB register (zeros).
- Illegal input: pipe_advance=1 while dmem_stall=1 is an illegal input combination; the bench asserts it never occurs.

Test Plan:
- ALU op: in_valid=1, wb_sel=0, alu_out=0x1234, rd=5, pipe_advance=1 -> same cycle regf_we=1, wdata=0x1234, rvfi_valid=1, order=0; next commit shows order=1.
- lb with off=3, dmem_rdata=0x80FF_0000, resp 3 cycles late -> dmem_stall=1 for 3 cycles, then 0. On the resp cycle: wdata=0xFFFF_FF80, rvfi_mem_rdata=0x80FF_0000.
- lhu off=2, resp same cycle as the instruction arrives, pipe_advance=0 for 2 cycles, dmem_rdata changes to 0 afterwards -> DONE holds. On advance, wdata=0x0000_80FF from the held 0x80FF_xxxx word.
- sw resp in WAIT; store to rd=0; lw to rd=0 -> regf_we=0 in all three; rvfi_valid=1 each; rd_addr=0, rd_wdata=0.
- Spurious dmem_resp during a bubble and in DONE -> dmem_resp_err pulses 1 cycle; rdata_hold unchanged; no stall.
- rst asserted in WAIT -> next cycle IDLE, dmem_stall=0, order=0. A late dmem_resp then pulses dmem_resp_err (bubble input) without committing.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage of the rv32i pipeline: waits for the data-memory response,
// aligns load data, drives the register-file write port and RVFI commit outputs.
module wb_stage #(
  parameter int unsigned ORDER_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pipe_advance,
  input  logic               in_valid,
  input  logic [4:0]         in_rd_addr,
  input  logic [31:0]        in_alu_out,
  input  logic [31:0]        in_pc_next,
  input  logic [1:0]         in_wb_sel,
  input  logic               in_regf_we,
  input  logic [2:0]         in_funct3,
  input  logic [3:0]         in_mem_rmask,
  input  logic [3:0]         in_mem_wmask,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_resp,
  output logic               dmem_stall,
  output logic               dmem_resp_err,
  output logic               regf_we,
  output logic [4:0]         regf_rd_addr,
  output logic [31:0]        regf_wdata,
  output logic               rvfi_valid,
  output logic [ORDER_W-1:0] rvfi_order,
  output logic [4:0]         rvfi_rd_addr,
  output logic [31:0]        rvfi_rd_wdata,
  output logic [31:0]        rvfi_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t               state;
  logic [31:0]          rdata_hold;
  logic [ORDER_W-1:0]   order_cnt;

  logic                 mem_acc;
  logic                 commit;
  logic [31:0]          load_word;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [31:0]          load_data;

  always_comb begin
    mem_acc       = in_valid & ((in_mem_rmask != '0) | (in_mem_wmask != '0));
    dmem_stall    = 1'b0;
    dmem_resp_err = 1'b0;
    case (state)
      IDLE: begin
        dmem_stall    = mem_acc & ~dmem_resp;
        dmem_resp_err = dmem_resp & ~mem_acc;
      end
      WAIT:    dmem_stall    = ~dmem_resp;
      DONE:    dmem_resp_err = dmem_resp;
      default: ;
    endcase
  end

  // Once the response has been captured, the bus word may change under a stall.
  always_comb begin
    load_word = (state == DONE) ? rdata_hold : dmem_rdata;
    ld_byte   = load_word[8*in_alu_out[1:0] +: 8];
    ld_half   = in_alu_out[1] ? load_word[31:16] : load_word[15:0];
    case (in_funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'd0, ld_half};
      3'b010:  load_data = load_word;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    case (in_wb_sel)
      2'd0:    regf_wdata = in_alu_out;
      2'd1:    regf_wdata = load_data;
      2'd2:    regf_wdata = in_pc_next;
      default: regf_wdata = '0;
    endcase
  end

  always_comb begin
    commit         = pipe_advance & in_valid & ~dmem_stall;
    regf_we        = commit & in_regf_we & (in_rd_addr != '0);
    regf_rd_addr   = in_rd_addr;
    rvfi_valid     = commit;
    rvfi_order     = order_cnt;
    rvfi_rd_addr   = regf_we ? in_rd_addr : '0;
    rvfi_rd_wdata  = regf_we ? regf_wdata : '0;
    rvfi_mem_rdata = (in_mem_rmask != '0) ? load_word : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rdata_hold <= '0;
      order_cnt  <= '0;
    end else begin
      if (commit)
        order_cnt <= order_cnt + ORDER_W'(1);
      case (state)
        IDLE: begin
          if (mem_acc) begin
            if (!dmem_resp) begin
              state <= WAIT;
            end else if (!pipe_advance) begin
              rdata_hold <= dmem_rdata;
              state      <= DONE;
            end
          end
        end
        WAIT: begin
          if (dmem_resp) begin
            if (pipe_advance) begin
              state <= IDLE;
            end else begin
              rdata_hold <= dmem_rdata;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          if (pipe_advance)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: vector table, directed multi-cycle sequences and a
// randomized run against a transaction-level reference model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_advance;
  logic        in_valid;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_alu_out;
  logic [31:0] in_pc_next;
  logic [1:0]  in_wb_sel;
  logic        in_regf_we;
  logic [2:0]  in_funct3;
  logic [3:0]  in_mem_rmask;
  logic [3:0]  in_mem_wmask;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_stall;
  logic        dmem_resp_err;
  logic        regf_we;
  logic [4:0]  regf_rd_addr;
  logic [31:0] regf_wdata;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_mem_rdata;

  int n_vec  = 0;
  int n_miss = 0;

  wb_stage #(.ORDER_W(64)) dut (
    .clk(clk), .rst(rst), .pipe_advance(pipe_advance), .in_valid(in_valid),
    .in_rd_addr(in_rd_addr), .in_alu_out(in_alu_out), .in_pc_next(in_pc_next),
    .in_wb_sel(in_wb_sel), .in_regf_we(in_regf_we), .in_funct3(in_funct3),
    .in_mem_rmask(in_mem_rmask), .in_mem_wmask(in_mem_wmask),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dmem_stall(dmem_stall),
    .dmem_resp_err(dmem_resp_err), .regf_we(regf_we), .regf_rd_addr(regf_rd_addr),
    .regf_wdata(regf_wdata), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_mem_rdata(rvfi_mem_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      assert (!(pipe_advance === 1'b1 && dmem_stall === 1'b1))
      else begin
        n_miss++;
        $error("FAIL illegal_advance: pipe_advance=1 while dmem_stall=1");
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rd, input logic [31:0] alu,
                           input logic [1:0] sel, input logic we, input logic [2:0] f3,
                           input logic [3:0] rm, input logic [3:0] wm);
    in_valid     = v;
    in_rd_addr   = rd;
    in_alu_out   = alu;
    in_pc_next   = 32'h0000_0100;
    in_wb_sel    = sel;
    in_regf_we   = we;
    in_funct3    = f3;
    in_mem_rmask = rm;
    in_mem_wmask = wm;
  endtask

  task automatic bubble();
    set_instr(1'b0, 5'd0, 32'd0, 2'd0, 1'b0, 3'd0, 4'd0, 4'd0);
    in_pc_next = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference load alignment expressed as shift-and-extend arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? b - 32'h100 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'b101:  return h;
      3'b010:  return w;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [3:0]  rmask;
    logic [4:0]  rd;
    logic [31:0] exp_wdata;
    logic        exp_we;
  } vec_t;

  vec_t tbl[12];

  // Model state: whether the instruction now in WB already got its response.
  bit          m_seen;
  logic [31:0] m_word;
  logic [63:0] m_order;

  initial begin
    tbl[0]  = '{3'b000, 2'd0, 32'h0000_1234, 32'h0,          4'b0000, 5'd5,  32'h0000_1234, 1'b1};
    tbl[1]  = '{3'b000, 2'd1, 32'h0000_1003, 32'h80FF_0000, 4'b1000, 5'd6,  32'hFFFF_FF80, 1'b1};
    tbl[2]  = '{3'b100, 2'd1, 32'h0000_2001, 32'h0000_8100, 4'b0010, 5'd7,  32'h0000_0081, 1'b1};
    tbl[3]  = '{3'b001, 2'd1, 32'h0000_3002, 32'h80FF_1234, 4'b1100, 5'd8,  32'hFFFF_80FF, 1'b1};
    tbl[4]  = '{3'b101, 2'd1, 32'h0000_4000, 32'h1234_F00D, 4'b0011, 5'd9,  32'h0000_F00D, 1'b1};
    tbl[5]  = '{3'b010, 2'd1, 32'h0000_5000, 32'hDEAD_BEEF, 4'b1111, 5'd10, 32'hDEAD_BEEF, 1'b1};
    tbl[6]  = '{3'b011, 2'd1, 32'h0000_6000, 32'hDEAD_BEEF, 4'b1111, 5'd11, 32'h0000_0000, 1'b1};
    tbl[7]  = '{3'b000, 2'd2, 32'h0000_7000, 32'h0,          4'b0000, 5'd12, 32'h0000_0100, 1'b1};
    tbl[8]  = '{3'b000, 2'd3, 32'h0000_8000, 32'h0,          4'b0000, 5'd13, 32'h0000_0000, 1'b1};
    tbl[9]  = '{3'b000, 2'd0, 32'h0000_9999, 32'h0,          4'b0000, 5'd0,  32'h0000_9999, 1'b0};
    tbl[10] = '{3'b000, 2'd1, 32'h0000_A000, 32'h0000_007F, 4'b0001, 5'd14, 32'h0000_007F, 1'b1};
    tbl[11] = '{3'b001, 2'd1, 32'h0000_B000, 32'h0000_8000, 4'b0011, 5'd15, 32'hFFFF_8000, 1'b1};

    rst = 1'b1;
    pipe_advance = 1'b0;
    dmem_resp = 1'b0;
    dmem_rdata = 32'd0;
    bubble();
    repeat (2) next_cycle();
    rst = 1'b0;
    #1;
    chk("rst_stall", 64'(dmem_stall), 64'd0);
    chk("rst_err",   64'(dmem_resp_err), 64'd0);
    chk("rst_we",    64'(regf_we), 64'd0);
    chk("rst_valid", 64'(rvfi_valid), 64'd0);
    chk("rst_order", rvfi_order, 64'd0);

    // Single-cycle commits, response in the same cycle.
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      set_instr(1'b1, tbl[i].rd, tbl[i].alu, tbl[i].sel, 1'b1, tbl[i].f3, tbl[i].rmask, 4'd0);
      dmem_rdata   = tbl[i].rdata;
      dmem_resp    = (tbl[i].rmask != 4'd0);
      pipe_advance = 1'b1;
      #1;
      chk($sformatf("tbl%0d_wdata", i), 64'(regf_wdata), 64'(tbl[i].exp_wdata));
      chk($sformatf("tbl%0d_we", i),    64'(regf_we),    64'(tbl[i].exp_we));
      chk($sformatf("tbl%0d_valid", i), 64'(rvfi_valid), 64'd1);
      chk($sformatf("tbl%0d_order", i), rvfi_order,      64'(i));
      chk($sformatf("tbl%0d_stall", i), 64'(dmem_stall), 64'd0);
    end

    // lb off=3, response three cycles late.
    next_cycle();
    set_instr(1'b1, 5'd3, 32'h0000_1003, 2'd1, 1'b1, 3'b000, 4'b1000, 4'd0);
    dmem_resp = 1'b0; dmem_rdata = 32'h0; pipe_advance = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("late_stall%0d", c), 64'(dmem_stall), 64'd1);
      chk($sformatf("late_nocommit%0d", c), 64'(rvfi_valid), 64'd0);
      next_cycle();
    end
    dmem_resp = 1'b1; dmem_rdata = 32'h80FF_0000; pipe_advance = 1'b1;
    #1;
    chk("late_stall_end", 64'(dmem_stall), 64'd0);
    chk("late_wdata", 64'(regf_wdata), 64'hFFFF_FF80);
    chk("late_memrd", 64'(rvfi_mem_rdata), 64'h80FF_0000);
    chk("late_valid", 64'(rvfi_valid), 64'd1);

    // lhu off=2, response on arrival, held through two stalled cycles.
    next_cycle();
    set_instr(1'b1, 5'd4, 32'h0000_2002, 2'd1, 1'b1, 3'b101, 4'b1100, 4'd0);
    dmem_resp = 1'b1; dmem_rdata = 32'h80FF_1234; pipe_advance = 1'b0;
    #1;
    chk("hold_stall0", 64'(dmem_stall), 64'd0);
    chk("hold_nocommit0", 64'(rvfi_valid), 64'd0);
    next_cycle();
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    #1;
    chk("hold_wdata1", 64'(regf_wdata), 64'h0000_80FF);
    chk("hold_nocommit1", 64'(rvfi_valid), 64'd0);
    next_cycle();
    pipe_advance = 1'b1;
    #1;
    chk("hold_wdata", 64'(regf_wdata), 64'h0000_80FF);
    chk("hold_valid", 64'(rvfi_valid), 64'd1);
    chk("hold_memrd", 64'(rvfi_mem_rdata), 64'h80FF_1234);

    // sw with response in WAIT, store to rd=0, lw to rd=0.
    next_cycle();
    set_instr(1'b1, 5'd7, 32'h0000_3000, 2'd0, 1'b0, 3'b010, 4'd0, 4'b1111);
    dmem_resp = 1'b0; pipe_advance = 1'b0;
    #1;
    chk("sw_stall", 64'(dmem_stall), 64'd1);
    next_cycle();
    dmem_resp = 1'b1; pipe_advance = 1'b1;
    #1;
    chk("sw_we", 64'(regf_we), 64'd0);
    chk("sw_valid", 64'(rvfi_valid), 64'd1);
    chk("sw_rvfi_rd", 64'({rvfi_rd_addr, rvfi_rd_wdata}), 64'd0);
    next_cycle();
    set_instr(1'b1, 5'd0, 32'h0000_3004, 2'd0, 1'b0, 3'b010, 4'd0, 4'b0011);
    #1;
    chk("sw0_we", 64'(regf_we), 64'd0);
    chk("sw0_valid", 64'(rvfi_valid), 64'd1);
    chk("sw0_rvfi_rd", 64'({rvfi_rd_addr, rvfi_rd_wdata}), 64'd0);
    next_cycle();
    set_instr(1'b1, 5'd0, 32'h0000_3008, 2'd1, 1'b1, 3'b010, 4'b1111, 4'd0);
    dmem_rdata = 32'hCAFE_F00D;
    #1;
    chk("lw0_we", 64'(regf_we), 64'd0);
    chk("lw0_valid", 64'(rvfi_valid), 64'd1);
    chk("lw0_rvfi_rd", 64'({rvfi_rd_addr, rvfi_rd_wdata}), 64'd0);
    chk("lw0_memrd", 64'(rvfi_mem_rdata), 64'hCAFE_F00D);

    // Spurious responses during a bubble and while holding data.
    next_cycle();
    bubble();
    dmem_resp = 1'b1; pipe_advance = 1'b0;
    #1;
    chk("bub_err", 64'(dmem_resp_err), 64'd1);
    chk("bub_stall", 64'(dmem_stall), 64'd0);
    next_cycle();
    dmem_resp = 1'b0;
    #1;
    chk("bub_err_clr", 64'(dmem_resp_err), 64'd0);
    next_cycle();
    set_instr(1'b1, 5'd9, 32'h0000_4000, 2'd1, 1'b1, 3'b010, 4'b1111, 4'd0);
    dmem_resp = 1'b1; dmem_rdata = 32'h1111_2222;
    #1;
    chk("done_err0", 64'(dmem_resp_err), 64'd0);
    next_cycle();
    dmem_rdata = 32'h3333_4444;
    #1;
    chk("done_err", 64'(dmem_resp_err), 64'd1);
    chk("done_stall", 64'(dmem_stall), 64'd0);
    chk("done_wdata", 64'(regf_wdata), 64'h1111_2222);
    next_cycle();
    dmem_resp = 1'b0; pipe_advance = 1'b1;
    #1;
    chk("done_err_clr", 64'(dmem_resp_err), 64'd0);
    chk("done_keep", 64'(regf_wdata), 64'h1111_2222);
    chk("done_valid", 64'(rvfi_valid), 64'd1);

    // Reset while waiting for a response.
    next_cycle();
    set_instr(1'b1, 5'd2, 32'h0000_5000, 2'd1, 1'b1, 3'b010, 4'b1111, 4'd0);
    dmem_resp = 1'b0; pipe_advance = 1'b0;
    #1;
    chk("rw_stall", 64'(dmem_stall), 64'd1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    bubble();
    #1;
    chk("rw_stall_clr", 64'(dmem_stall), 64'd0);
    chk("rw_order", rvfi_order, 64'd0);
    next_cycle();
    dmem_resp = 1'b1; dmem_rdata = 32'h5555_AAAA; pipe_advance = 1'b1;
    #1;
    chk("rw_late_err", 64'(dmem_resp_err), 64'd1);
    chk("rw_late_nocommit", 64'(rvfi_valid), 64'd0);
    chk("rw_late_we", 64'(regf_we), 64'd0);

    // Randomized run against the reference model.
    next_cycle();
    rst = 1'b1; pipe_advance = 1'b0; dmem_resp = 1'b0;
    next_cycle();
    rst = 1'b0;
    m_seen = 1'b0; m_word = 32'd0; m_order = 64'd0;
    begin
      bit          prev_adv;
      bit          m_acc, m_stall, m_err, m_commit, m_we;
      logic [31:0] m_load, m_wdata, m_src;
      prev_adv = 1'b1;
      for (int n = 0; n < 600; n++) begin
        if (n != 0) next_cycle();
        if (prev_adv) begin
          int unsigned kind;
          kind = $urandom_range(0, 2);
          set_instr(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 31)), $urandom,
                    2'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 7)),
                    (kind == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                    (kind == 1) ? 4'($urandom_range(1, 15)) : 4'd0);
          in_pc_next = $urandom;
        end
        dmem_resp  = ($urandom_range(0, 2) == 0);
        dmem_rdata = $urandom;

        m_acc   = in_valid && (in_mem_rmask != 0 || in_mem_wmask != 0);
        m_stall = m_acc && !m_seen && !dmem_resp;
        m_err   = dmem_resp && (!m_acc || m_seen);
        pipe_advance = !m_stall && ($urandom_range(0, 1) == 1);
        m_commit = pipe_advance && in_valid && !m_stall;
        m_we     = m_commit && in_regf_we && in_rd_addr != 0;
        m_src    = m_seen ? m_word : dmem_rdata;
        m_load   = ref_load(m_src, in_funct3, in_alu_out[1:0]);
        m_wdata  = (in_wb_sel == 0) ? in_alu_out : (in_wb_sel == 1) ? m_load :
                   (in_wb_sel == 2) ? in_pc_next : 32'd0;
        #1;
        chk("rnd_stall", 64'(dmem_stall), 64'(m_stall));
        chk("rnd_err",   64'(dmem_resp_err), 64'(m_err));
        chk("rnd_valid", 64'(rvfi_valid), 64'(m_commit));
        chk("rnd_we",    64'(regf_we), 64'(m_we));
        chk("rnd_wdata", 64'(regf_wdata), 64'(m_wdata));
        chk("rnd_order", rvfi_order, m_order);
        chk("rnd_rvfi_rd", 64'({rvfi_rd_addr, rvfi_rd_wdata}),
            m_we ? 64'({in_rd_addr, m_wdata}) : 64'd0);
        chk("rnd_memrd", 64'(rvfi_mem_rdata), (in_mem_rmask != 0) ? 64'(m_src) : 64'd0);

        if (m_commit) m_order++;
        if (pipe_advance) m_seen = 1'b0;
        else if (m_acc && dmem_resp && !m_seen) begin
          m_seen = 1'b1;
          m_word = dmem_rdata;
        end
        prev_adv = pipe_advance;
      end
    end

    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
